// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared width limits and result record for the full_adder slice.
package full_adder_pkg;
  localparam int FA_WIDTH_DEFAULT = 1;
  localparam int FA_WIDTH_MAX = 64;
  typedef struct packed {
    logic cout;
    logic [FA_WIDTH_MAX-1:0] sum;
    logic ovf;
  } result_t;
endpackage

// File: rtl/full_adder_half_adder.sv
// half_adder: combinational one-bit half adder, two per full-adder bit stage.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

// File: rtl/full_adder.sv
// full_adder: registered WIDTH-bit ripple-carry adder with one-cycle latency.
// Define FULL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  logic [WIDTH:0] carry;
  logic [WIDTH-1:0] p, s, c_lo, c_hi;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic cout_d, cout_q, valid_d, valid_q;
  assign carry[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    half_adder u_ha0 (.x(a[i]), .y(b[i]), .s(p[i]), .c(c_lo[i]));
    half_adder u_ha1 (.x(p[i]), .y(carry[i]), .s(s[i]), .c(c_hi[i]));
    assign carry[i+1] = c_lo[i] | c_hi[i];
  end
  // Idle cycles keep the last result so operands are don't-care without in_valid.
  always_comb begin
    sum_d   = in_valid ? s : sum_q;
    cout_d  = in_valid ? carry[WIDTH] : cout_q;
    valid_d = in_valid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;
`ifdef FULL_ADDER_OVF_EN
  logic ovf_d, ovf_q;
  always_comb begin
    ovf_d = in_valid ? carry[WIDTH-1] ^ carry[WIDTH] : ovf_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: scoreboard bench driving WIDTH=1, 8 and 16 adders from one clock.
module tb_full_adder;
  typedef struct packed {
    logic valid;
    logic [15:0] sum;
    logic cout;
    logic ovf;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a1, b1, ci1, iv1, s1, co1, ov1;
  logic [7:0] a8, b8, s8;
  logic ci8, iv8, co8, ov8;
  logic [15:0] a16, b16, s16;
  logic ci16, iv16, co16, ov16;
`ifdef FULL_ADDER_OVF_EN
  logic of1, of8, of16;
`endif

  int n_vec = 0;
  int n_bad = 0;
  entry_t q1[$], q8[$], q16[$];
  entry_t h1 = '0, h8 = '0, h16 = '0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(ci1), .in_valid(iv1),
    .sum(s1), .cout(co1), .out_valid(ov1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(of1)
`endif
  );
  full_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(ci8), .in_valid(iv8),
    .sum(s8), .cout(co8), .out_valid(ov8)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(of8)
`endif
  );
  full_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(ci16), .in_valid(iv16),
    .sum(s16), .cout(co16), .out_valid(ov16)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(of16)
`endif
  );

  task automatic chk(input string n, input entry_t e, input logic v, input logic [15:0] s,
                     input logic c, input logic o);
    logic bad;
    bad = (v !== e.valid) || (s !== e.sum) || (c !== e.cout);
`ifdef FULL_ADDER_OVF_EN
    bad = bad || (o !== e.ovf);
`endif
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got v=%b sum=%h cout=%b ovf=%b, want v=%b sum=%h cout=%b ovf=%b",
               n, v, s, c, o, e.valid, e.sum, e.cout, e.ovf);
    end
  endtask

  // Monitor: one scoreboard entry per DUT per clock, compared away from the active edge.
  always @(negedge clk) begin
    logic o1, o8, o16;
`ifdef FULL_ADDER_OVF_EN
    o1 = of1; o8 = of8; o16 = of16;
`else
    o1 = 1'b0; o8 = 1'b0; o16 = 1'b0;
`endif
    if (q1.size() > 0) chk("w1", q1.pop_front(), ov1, {15'b0, s1}, co1, o1);
    if (q8.size() > 0) chk("w8", q8.pop_front(), ov8, {8'b0, s8}, co8, o8);
    if (q16.size() > 0) chk("w16", q16.pop_front(), ov16, s16, co16, o16);
  end

  // Drive one cycle to DUT of width w; the other two stay idle and must hold.
  task automatic drive(input int w, input logic [15:0] av, input logic [15:0] bv,
                       input logic c, input logic v, input logic [15:0] es,
                       input logic ec, input logic eo);
    entry_t e;
    a1 = av[0]; b1 = bv[0]; ci1 = c; iv1 = v && (w == 1);
    a8 = av[7:0]; b8 = bv[7:0]; ci8 = c; iv8 = v && (w == 8);
    a16 = av; b16 = bv; ci16 = c; iv16 = v && (w == 16);
    @(posedge clk);
    e = '{valid: 1'b1, sum: es, cout: ec, ovf: eo};
    if (iv1) h1 = e;
    if (iv8) h8 = e;
    if (iv16) h16 = e;
    if (rst_n) begin
      q1.push_back('{valid: iv1, sum: h1.sum, cout: h1.cout, ovf: h1.ovf});
      q8.push_back('{valid: iv8, sum: h8.sum, cout: h8.cout, ovf: h8.ovf});
      q16.push_back('{valid: iv16, sum: h16.sum, cout: h16.cout, ovf: h16.ovf});
    end
    #1;
  endtask

  task automatic chk_zero(input string n);
    entry_t z;
    z = '0;
    chk({n, "_w1"}, z, ov1, {15'b0, s1}, co1, 1'b0);
    chk({n, "_w16"}, z, ov16, s16, co16, 1'b0);
  endtask

  initial begin
    logic [1:0] exp1[8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    logic ovf1[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0] v3;
    logic [16:0] r;
    logic [15:0] ra, rb;
    logic rc, rv;
    {a1, b1, ci1, iv1, a8, b8, ci8, iv8, a16, b16, ci16, iv16} = '0;
    #1 chk_zero("reset_state");
    #11 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v3 = 3'(i);
      drive(1, {15'b0, v3[2]}, {15'b0, v3[1]}, v3[0], 1'b1, {15'b0, exp1[i][0]}, exp1[i][1], ovf1[i]);
    end
    drive(1, 16'h0, 16'h1, 1'b1, 1'b1, 16'h0, 1'b1, 1'b0);
    drive(1, 16'hxxxx, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1, 16'hxxxx, 16'hxxxx, 1'bx, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(8, 16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    drive(8, 16'h00FF, 16'h00FF, 1'b1, 1'b1, 16'h00FF, 1'b1, 1'b0);
    drive(8, 16'h007F, 16'h0001, 1'b0, 1'b1, 16'h0080, 1'b0, 1'b1);
    drive(8, 16'h0080, 16'h0080, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
    drive(8, 16'h003C, 16'h00A5, 1'b1, 1'b1, 16'h00E2, 1'b0, 1'b0);
    drive(8, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    drive(16, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    drive(16, 16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
    drive(1, 16'h1, 16'h1, 1'b1, 1'b1, 16'h1, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_async");
    a1 = 1'b0; b1 = 1'b1; ci1 = 1'b0; iv1 = 1'b1;
    @(posedge clk);
    #1 chk_zero("reset_hold");
    @(negedge clk);
    #2 rst_n = 1'b1;
    {h1, h8, h16} = '0;
    drive(1, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rv = ($urandom % 4) != 0;
      r = 17'(ra) + 17'(rb) + 17'(rc);
      drive(16, ra, rb, rc, rv, r[15:0], r[16], (ra[15] == rb[15]) && (r[15] != ra[15]));
    end
    drive(16, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    n_vec++;
    if (q1.size() + q8.size() + q16.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left, want 0", q1.size() + q8.size() + q16.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
